// File: rtl/clap_sequencer.sv
// clap_sequencer: groups debounced claps into sequences and emits the count as a command code.
// Latency: clap_edge 3 cycles after clap_pulse_i rises; cmd_valid_o GAP_MAX cycles after the last accepted edge.
// Backpressure: cmd_valid_o/cmd_code_o held in HOLD until cmd_ready_i; claps seen in HOLD pulse drop_o and are discarded.
//
// Ports:
//   clk_i, rst_ni        system clock, asynchronous active-low reset
//   clap_pulse_i         detector pulse, asynchronous to clk_i, high >= 2 cycles
//   enable_i             sequencing enable (ignored while a command is pending)
//   cmd_ready_i          consumer ready
//   cmd_valid_o          command available
//   cmd_code_o           clap count 1..MAX_CLAPS, 0 = overflow
//   busy_o               state is not IDLE
//   drop_o               one-cycle pulse for a clap discarded in HOLD
module clap_sequencer #(
    parameter int GAP_MIN   = 5_000_000,
    parameter int GAP_MAX   = 50_000_000,
    parameter int MAX_CLAPS = 3,
    parameter int CODE_W    = $clog2(MAX_CLAPS + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clap_pulse_i,
    input  logic              enable_i,
    input  logic              cmd_ready_i,
    output logic              cmd_valid_o,
    output logic [CODE_W-1:0] cmd_code_o,
    output logic              busy_o,
    output logic              drop_o
);

    localparam int TMR_W = $clog2(GAP_MAX + 1);
    localparam int CNT_W = CODE_W + 1;

    localparam logic [TMR_W-1:0] TMR_MIN  = TMR_W'(GAP_MIN);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GAP_MAX - 1);
    localparam logic [TMR_W-1:0] TMR_SAT  = TMR_W'(GAP_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CLAPS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_CLAPS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Input path: two synchroniser flops, a delayed copy, and a registered rising-edge strobe.
    logic r_sync1;
    logic r_sync2;
    logic r_sync2_d;
    logic r_clap_edge;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync2_d   <= 1'b0;
            r_clap_edge <= 1'b0;
        end else begin
            r_sync1     <= clap_pulse_i;
            r_sync2     <= r_sync1;
            r_sync2_d   <= r_sync2;
            r_clap_edge <= r_sync2 & ~r_sync2_d;
        end
    end

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [TMR_W-1:0]   r_timer;
    logic               r_valid;
    logic [CODE_W-1:0]  r_code;
    logic               r_busy;
    logic               r_drop;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [TMR_W-1:0]   w_timer_nxt;
    logic               w_valid_nxt;
    logic [CODE_W-1:0]  w_code_nxt;
    logic               w_drop_nxt;
    logic               w_accept;

    // Edges arriving inside the debounce window are ignored without restarting the timer.
    assign w_accept = r_clap_edge && (r_timer >= TMR_MIN);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_timer_nxt = r_timer;
        w_valid_nxt = r_valid;
        w_code_nxt  = r_code;
        w_drop_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (r_clap_edge && enable_i) begin
                    w_state_nxt = ST_COUNT;
                    w_cnt_nxt   = CNT_W'(1);
                    w_timer_nxt = '0;
                end
            end
            ST_COUNT: begin
                if (!enable_i) begin
                    // Partial sequence is abandoned silently.
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_timer_nxt = '0;
                end else if (w_accept) begin
                    // An accepted clap beats a coincident timeout.
                    w_cnt_nxt   = (r_cnt >= CNT_SAT) ? CNT_SAT : r_cnt + 1'b1;
                    w_timer_nxt = '0;
                end else if (r_timer == TMR_LAST) begin
                    w_state_nxt = ST_HOLD;
                    w_timer_nxt = TMR_SAT;
                    w_valid_nxt = 1'b1;
                    w_code_nxt  = (r_cnt > CNT_MAX) ? '0 : r_cnt[CODE_W-1:0];
                end else if (r_timer != TMR_SAT) begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            ST_HOLD: begin
                // Includes the transfer cycle itself: the block is still HOLD there.
                w_drop_nxt = r_clap_edge;
                if (r_valid && cmd_ready_i) begin
                    w_state_nxt = ST_IDLE;
                    w_valid_nxt = 1'b0;
                    w_code_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_timer_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_timer_nxt = '0;
                w_valid_nxt = 1'b0;
                w_code_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_timer <= '0;
            r_valid <= 1'b0;
            r_code  <= '0;
            r_busy  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_timer <= w_timer_nxt;
            r_valid <= w_valid_nxt;
            r_code  <= w_code_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_drop  <= w_drop_nxt;
        end
    end

    assign cmd_valid_o = r_valid;
    assign cmd_code_o  = r_code;
    assign busy_o      = r_busy;
    assign drop_o      = r_drop;

endmodule

// File: tb/tb_clap_sequencer.sv
// tb_clap_sequencer: directed vectors plus hand-written corner sequences for clap_sequencer.
// Timing reference: a pulse driven just after tick t is accepted at posedge t+4,
// so busy_o is seen at t+4 and cmd_valid_o at t+4+GAP_MAX = t+24.
module tb_clap_sequencer;

    localparam int GAP_MIN   = 4;
    localparam int GAP_MAX   = 20;
    localparam int MAX_CLAPS = 3;
    localparam int CODE_W    = 2;

    logic              clk_i        = 1'b0;
    logic              rst_ni       = 1'b0;
    logic              clap_pulse_i = 1'b0;
    logic              enable_i     = 1'b1;
    logic              cmd_ready_i  = 1'b1;
    logic              cmd_valid_o;
    logic [CODE_W-1:0] cmd_code_o;
    logic              busy_o;
    logic              drop_o;

    int total = 0;
    int bad   = 0;

    clap_sequencer #(
        .GAP_MIN  (GAP_MIN),
        .GAP_MAX  (GAP_MAX),
        .MAX_CLAPS(MAX_CLAPS),
        .CODE_W   (CODE_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clap_pulse_i(clap_pulse_i),
        .enable_i    (enable_i),
        .cmd_ready_i (cmd_ready_i),
        .cmd_valid_o (cmd_valid_o),
        .cmd_code_o  (cmd_code_o),
        .busy_o      (busy_o),
        .drop_o      (drop_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string name;
        int    off [4];   // tick offsets of 2-cycle pulses, negative = unused
        int    code;      // expected cmd_code_o
        int    lat;       // tick at which cmd_valid_o is first seen
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_outs_zero(input string name);
        check({name, "_valid"}, int'(cmd_valid_o), 0);
        check({name, "_code"},  int'(cmd_code_o),  0);
        check({name, "_busy"},  int'(busy_o),      0);
        check({name, "_drop"},  int'(drop_o),      0);
    endtask

    // Plays one vector with enable=1, ready=1 and checks emission timing and shape.
    task automatic run_vec(input vec_t v);
        int seen_v = -1;
        int seen_b = -1;
        int code   = -1;
        int nvalid = 0;
        int drops  = 0;
        for (int t = 0; t < 70; t++) begin
            logic p;
            p = 1'b0;
            for (int k = 0; k < 4; k++)
                if (v.off[k] >= 0 && t >= v.off[k] && t < v.off[k] + 2) p = 1'b1;
            clap_pulse_i = p;
            tick();
            if (busy_o && seen_b < 0) seen_b = t + 1;
            if (drop_o) drops++;
            if (cmd_valid_o) begin
                nvalid++;
                if (seen_v < 0) begin
                    seen_v = t + 1;
                    code   = int'(cmd_code_o);
                end
            end
        end
        check({v.name, "_lat"},      seen_v, v.lat);
        check({v.name, "_code"},     code,   v.code);
        check({v.name, "_vcycles"},  nvalid, 1);
        check({v.name, "_busyrise"}, seen_b, 4);
        check({v.name, "_busyend"},  int'(busy_o), 0);
        check({v.name, "_drops"},    drops,  0);
    endtask

    initial begin
        int cnt_a;
        int cnt_b;
        int cnt_c;
        int tick_d;

        vecs[0] = '{"single",   '{0, -1, -1, -1},  1, 24};
        vecs[1] = '{"bounce",   '{0,  3, 10, -1},  2, 34};
        vecs[2] = '{"deb_lo",   '{0,  4, -1, -1},  1, 24};
        vecs[3] = '{"deb_hi",   '{0,  5, -1, -1},  2, 29};
        vecs[4] = '{"triple",   '{0,  8, 16, -1},  3, 40};
        vecs[5] = '{"overflow", '{0,  8, 16, 24},  0, 48};
        vecs[6] = '{"race",     '{0, 20, -1, -1},  2, 44};

        // Reset state
        tick();
        tick();
        check_outs_zero("rst_init");
        #2 rst_ni = 1'b1;
        tick();
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: ready low through the HOLD, one clap during HOLD
        cmd_ready_i = 1'b0;
        cnt_a = 0; cnt_b = 0; tick_d = -1;
        for (int t = 0; t < 45; t++) begin
            clap_pulse_i = (t == 0 || t == 1 || t == 28 || t == 29);
            if (t == 39) cmd_ready_i = 1'b1;
            tick();
            if (t + 1 >= 24 && t + 1 <= 39 && cmd_valid_o && cmd_code_o == 2'd1) cnt_a++;
            if (drop_o) begin
                cnt_b++;
                if (tick_d < 0) tick_d = t + 1;
            end
            if (t + 1 == 40) begin
                check("bp_valid_after", int'(cmd_valid_o), 0);
                check("bp_busy_after",  int'(busy_o),      0);
            end
        end
        check("bp_hold_cycles", cnt_a, 16);
        check("bp_drop_count",  cnt_b, 1);
        check("bp_drop_tick",   tick_d, 32);

        // Enable dropped mid-COUNT; a clap while disabled is ignored without drop
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int t = 0; t < 50; t++) begin
            clap_pulse_i = (t == 0 || t == 1 || t == 15 || t == 16);
            enable_i     = (t < 10 || t >= 30);
            tick();
            if (t + 1 == 10) check("en_busy_before", int'(busy_o), 1);
            if (t + 1 == 11) check("en_busy_next",   int'(busy_o), 0);
            if (cmd_valid_o) cnt_a++;
            if (t + 1 > 11 && busy_o) cnt_b++;
            if (drop_o) cnt_c++;
        end
        check("en_no_cmd",   cnt_a, 0);
        check("en_idle",     cnt_b, 0);
        check("en_no_drop",  cnt_c, 0);

        // Enable dropped in HOLD: command stays until handshake
        cmd_ready_i = 1'b0;
        cnt_a = 0;
        for (int t = 0; t < 40; t++) begin
            clap_pulse_i = (t == 0 || t == 1);
            if (t == 25) enable_i = 1'b0;
            if (t == 34) cmd_ready_i = 1'b1;
            tick();
            if (t + 1 >= 24 && t + 1 <= 34 && cmd_valid_o && cmd_code_o == 2'd1) cnt_a++;
            if (t + 1 == 35) begin
                check("enh_valid_after", int'(cmd_valid_o), 0);
                check("enh_busy_after",  int'(busy_o),      0);
            end
        end
        check("enh_hold_cycles", cnt_a, 11);
        enable_i = 1'b1;
        tick();

        // Reset mid-COUNT, asserted between clock edges
        for (int t = 0; t < 10; t++) begin
            clap_pulse_i = (t == 0 || t == 1);
            tick();
        end
        check("rstc_busy_before", int'(busy_o), 1);
        #2 rst_ni = 1'b0;
        #1 check_outs_zero("rst_count");
        tick();
        tick();
        #2 rst_ni = 1'b1;
        tick();
        tick();
        run_vec(vecs[0]);

        // Reset mid-HOLD
        cmd_ready_i = 1'b0;
        for (int t = 0; t < 30; t++) begin
            clap_pulse_i = (t == 0 || t == 1);
            tick();
        end
        check("rsth_valid_before", int'(cmd_valid_o), 1);
        #2 rst_ni = 1'b0;
        #1 check_outs_zero("rst_hold");
        tick();
        #2 rst_ni = 1'b1;
        cmd_ready_i = 1'b1;
        tick();
        tick();
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clap_sequencer.md
# clap_sequencer

Command sequencer that sits downstream of the clap detector. It synchronises the detector's `clap_pulse` into the system clock domain and debounces it. It groups claps that arrive close together into sequences, then emits the clap count as a command code over a valid/ready handshake. The consumer is the top-level control logic, for example an LED or relay toggling FSM.

## Interface

Parameters:
- `GAP_MIN`, default 5_000_000: debounce window in clk_i cycles. A clap edge that arrives sooner than this after the previous accepted clap is ignored.
- `GAP_MAX`, default 50_000_000: sequence timeout in clk_i cycles. A sequence closes after this many cycles without an accepted clap. Constraint: GAP_MAX > GAP_MIN ≥ 1.
- `MAX_CLAPS`, default 3: largest valid clap count.
- `CODE_W`, default $clog2(MAX_CLAPS+1): width of the command code.

Ports:
- `clk_i`, in, 1 bit: system clock (100 MHz).
- `rst_ni`, in, 1 bit: reset. One clock; reset is asynchronous and active-low.
- `clap_pulse_i`, in, 1 bit: clap pulse from the detector, asynchronous to clk_i (M_CLK domain). It stays high ≥ 2 clk_i cycles.
- `enable_i`, in, 1 bit: sequencing enable, synchronous to clk_i.
- `cmd_ready_i`, in, 1 bit: consumer ready.
- `cmd_valid_o`, out, 1 bit: command available.
- `cmd_code_o`, out, CODE_W bits: clap count, 1..MAX_CLAPS. Value 0 means overflow (more than MAX_CLAPS claps).
- `busy_o`, out, 1 bit: high when the state is not IDLE.
- `drop_o`, out, 1 bit: one-cycle pulse when an edge is discarded because the block is in HOLD.

## Operation

**Input path:**
- clap_pulse_i passes through a 2-flop synchroniser, then a rising-edge detect register.
- The result is `clap_edge`: one clk_i cycle per detector pulse.
- The synchroniser and edge register clear on reset.

**FSM states:** IDLE, COUNT, HOLD.

**Counters:**
- `cnt`: clap count, CODE_W+1 bits, saturating at MAX_CLAPS+1.
- `timer`: cycles since the last accepted clap, saturating at GAP_MAX.

**IDLE:**
- clap_edge && enable_i → COUNT, with cnt=1 and timer=0.
- clap_edge with enable_i low is ignored. drop_o stays 0.

**COUNT:**
- timer increments every cycle.
- An edge is accepted when clap_edge && timer ≥ GAP_MIN. On acceptance: cnt = min(cnt+1, MAX_CLAPS+1) and timer = 0.
- clap_edge with timer < GAP_MIN is ignored (debounce). The timer is not restarted.
- timer == GAP_MAX−1 with no accepted edge → HOLD. At the same time, register cmd_valid_o=1 and cmd_code_o = (cnt > MAX_CLAPS) ? 0 : cnt.
- Simultaneous accepted edge and timeout: the edge wins. The clap is counted, the timer restarts and there is no emission.
- enable_i low → IDLE next cycle. The partial sequence is discarded with no emission.

**HOLD:**
- cmd_valid_o and cmd_code_o stay stable until cmd_valid_o && cmd_ready_i.
- On handshake → IDLE. cmd_valid_o=0, cnt=0 and timer=0 in the next cycle.
- enable_i does not affect HOLD. A valid command is never withdrawn.
- Any clap_edge in HOLD produces drop_o=1 for that cycle and is otherwise ignored.

**Reset:** asynchronous assertion. From any state, including mid-sequence and mid-HOLD:
- state = IDLE, cnt = 0, timer = 0;
- cmd_valid_o = 0, cmd_code_o = 0, busy_o = 0, drop_o = 0.

## Timing

- Input latency: clap_edge is high 3 clk_i cycles after clap_pulse_i rises (2 sync + 1 edge register). There is ±1 cycle asynchronous uncertainty.
- busy_o is registered. It rises the cycle after the edge that enters COUNT.
- Emission latency: cmd_valid_o rises exactly GAP_MAX cycles after the cycle of the last accepted clap_edge.
- Handshake: a transfer occurs on any rising clk_i where cmd_valid_o && cmd_ready_i. cmd_ready_i may be high before valid.
- Throughput: at most one command per sequence. The block returns to IDLE one cycle after the transfer. An edge in that same transfer cycle is still HOLD and is dropped.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan

Use GAP_MIN=4, GAP_MAX=20, MAX_CLAPS=3, enable_i=1 and cmd_ready_i=1 unless stated otherwise.

1. **Single clap:** one pulse (4 cycles wide). Required: cmd_valid_o high for 1 cycle with cmd_code_o=1, exactly 20 cycles after clap_edge. busy_o returns to 0.
2. **Double clap with bounce:** pulses at edge-cycle 0, 2 and 10. Required: the cycle-2 edge is ignored and cmd_code_o=2. valid rises 20 cycles after the cycle-10 edge.
3. **Overflow and timeout race:** four accepted claps spaced 8 cycles. Required: cmd_code_o=0. Separately, an edge landing exactly at timer=19 is counted and the timeout is deferred.
4. **Backpressure:** cmd_ready_i=0 for 15 cycles after valid, with a clap arriving during HOLD. Required: valid and code held stable, and drop_o pulses once. The transfer happens when ready rises, followed by IDLE.
5. **Enable:** enable_i dropped mid-COUNT. Required: no command and IDLE next cycle. enable_i dropped in HOLD: valid is held until the handshake.
6. **Reset:** rst_ni asserted mid-COUNT and again mid-HOLD, asynchronously between clock edges. Required: all outputs are 0 immediately. The next clap starts a fresh sequence with code 1.
